// File: rtl/rasterint_multi.sv
// rasterint_multi: NCHAN raster-line compare channels with pending flags and a fixed-length int_n pulse.
// Define RASTERINT_HPOS_EN to add per-channel column compare (HPOS registers, CTRL bit5 = column[8]).
module rasterint_multi #(
   parameter int         NCHAN      = 4,
   parameter int         LINEW      = 9,
   parameter int         INT_CYCLES = 32,
   parameter logic [7:0] BASE_ADDR  = 8'h0C
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       zxuno_addr,
   input  logic             zxuno_regrd,
   input  logic             zxuno_regwr,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             oe,
   input  logic [LINEW-1:0] vcount,
   input  logic [8:0]       hcount,
   input  logic             line_start,
   output logic             int_n,
   output logic [NCHAN-1:0] pending,
   output logic             vretraceint_disable
);

   localparam logic [7:0] STATUS_OFF = 8'(2 * NCHAN);
   localparam int         HIW        = LINEW - 8;

   logic [LINEW-1:0] line_reg [NCHAN];
   logic [NCHAN-1:0] enable_reg;
   logic [NCHAN-1:0] pending_reg;
   logic             vret_dis;
   logic [7:0]       pulse_cnt;
   logic [7:0]       off;
   logic [NCHAN-1:0] fire;
   logic [NCHAN-1:0] ack;
   logic [7:0]       rd_val;
   logic             rd_hit;

`ifdef RASTERINT_HPOS_EN
   logic [8:0]       column_reg [NCHAN];
   logic             unused_line_start;
   assign unused_line_start = line_start;
`else
   logic             unused_hcount;
   assign unused_hcount = ^hcount;
`endif

   // Register offset relative to the block base; out-of-range offsets match nothing.
   assign off = zxuno_addr - BASE_ADDR;

   always_comb begin
      for (int i = 0; i < NCHAN; i++) begin
`ifdef RASTERINT_HPOS_EN
         fire[i] = enable_reg[i] && (vcount == line_reg[i]) && (hcount == column_reg[i]);
`else
         fire[i] = enable_reg[i] && line_start && (vcount == line_reg[i]);
`endif
      end
   end

   always_comb begin
      ack = '0;
      if (zxuno_regwr && (off == STATUS_OFF))
         ack = din[NCHAN-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCHAN; i++) begin
            line_reg[i] <= '1;
`ifdef RASTERINT_HPOS_EN
            column_reg[i] <= '0;
`endif
         end
         enable_reg <= '0;
         vret_dis   <= 1'b0;
      end else if (zxuno_regwr) begin
         for (int i = 0; i < NCHAN; i++) begin
            if (off == 8'(2 * i))
               line_reg[i][7:0] <= din;
            if (off == 8'(2 * i + 1)) begin
               enable_reg[i]          <= din[7];
               line_reg[i][LINEW-1:8] <= din[HIW-1:0];
`ifdef RASTERINT_HPOS_EN
               column_reg[i][8]       <= din[5];
`endif
            end
`ifdef RASTERINT_HPOS_EN
            if (off == 8'(2 * NCHAN + 1 + i))
               column_reg[i][7:0] <= din;
`endif
         end
         if (off == STATUS_OFF)
            vret_dis <= din[7];
      end
   end

   // A new fire sets pending even when the same bit is being acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending_reg <= '0;
      else
         pending_reg <= (pending_reg & ~ack) | fire;
   end

   // The pulse only starts from idle; fires during a pulse neither retrigger nor extend it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pulse_cnt <= '0;
      else if ((|fire) && (pulse_cnt == 8'd0))
         pulse_cnt <= 8'(INT_CYCLES);
      else if (pulse_cnt != 8'd0)
         pulse_cnt <= pulse_cnt - 8'd1;
   end

   always_comb begin
      rd_val = 8'h00;
      rd_hit = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (off == 8'(2 * i)) begin
            rd_hit = 1'b1;
            rd_val = line_reg[i][7:0];
         end
         if (off == 8'(2 * i + 1)) begin
            rd_hit             = 1'b1;
            rd_val             = {enable_reg[i], pending_reg[i], 6'b000000};
            rd_val[HIW-1:0]    = line_reg[i][LINEW-1:8];
`ifdef RASTERINT_HPOS_EN
            rd_val[5]          = column_reg[i][8];
`endif
         end
`ifdef RASTERINT_HPOS_EN
         if (off == 8'(2 * NCHAN + 1 + i)) begin
            rd_hit = 1'b1;
            rd_val = column_reg[i][7:0];
         end
`endif
      end
      if (off == STATUS_OFF) begin
         rd_hit             = 1'b1;
         rd_val             = 8'h00;
         rd_val[7]          = vret_dis;
         rd_val[NCHAN-1:0]  = pending_reg;
      end
   end

   always_comb begin
      oe   = 1'b0;
      dout = 8'hFF;
      if (zxuno_regrd && rd_hit) begin
         oe   = 1'b1;
         dout = rd_val;
      end
   end

   assign int_n               = (pulse_cnt == 8'd0);
   assign pending             = pending_reg;
   assign vretraceint_disable = vret_dis;

endmodule

// File: tb/tb_rasterint_multi.sv
// Self-checking bench for rasterint_multi (NCHAN=4, LINEW=9, INT_CYCLES=32, BASE_ADDR=8'h0C).
module tb_rasterint_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] zxuno_addr = 8'h00;
   logic       zxuno_regrd = 1'b0;
   logic       zxuno_regwr = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       oe;
   logic [8:0] vcount = 9'h000;
   logic [8:0] hcount = 9'h000;
   logic       line_start = 1'b0;
   logic       int_n;
   logic [3:0] pending;
   logic       vretraceint_disable;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   int         len_q [$];

   rasterint_multi #(
      .NCHAN(4), .LINEW(9), .INT_CYCLES(32), .BASE_ADDR(8'h0C)
   ) dut (
      .clk(clk), .rst(rst),
      .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
      .din(din), .dout(dout), .oe(oe),
      .vcount(vcount), .hcount(hcount), .line_start(line_start),
      .int_n(int_n), .pending(pending), .vretraceint_disable(vretraceint_disable)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      zxuno_addr  = a;
      din         = d;
      zxuno_regwr = 1'b1;
      @(negedge clk);
      zxuno_regwr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic o);
      @(negedge clk);
      zxuno_addr  = a;
      zxuno_regrd = 1'b1;
      #1;
      d = dout;
      o = oe;
      zxuno_regrd = 1'b0;
   endtask

   task automatic pulse_line(input logic [8:0] v);
      @(negedge clk);
      vcount     = v;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] rd, ev;
      logic       ro;
      #1;
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_int_n: got %b expected 1", int_n); end
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0000", pending); end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(8'hFF); bus_read(8'h0C, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev || ro !== 1'b1) begin errors++; $display("[TB] FAIL reset_line0: got %h oe %b expected %h oe 1", rd, ro, ev); end
      exp_q.push_back(8'h01); bus_read(8'h0D, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev || ro !== 1'b1) begin errors++; $display("[TB] FAIL reset_ctrl0: got %h oe %b expected %h oe 1", rd, ro, ev); end
      exp_q.push_back(8'h00); bus_read(8'h14, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev || ro !== 1'b1) begin errors++; $display("[TB] FAIL reset_status: got %h oe %b expected %h oe 1", rd, ro, ev); end
   endtask

   task automatic test_single_fire();
      logic [7:0] rd, ev;
      logic       ro;
      int         low;
      bus_write(8'h0C, 8'h23);
      bus_write(8'h0D, 8'h81);
      exp_q.push_back(8'h81); bus_read(8'h0D, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev || ro !== 1'b1) begin errors++; $display("[TB] FAIL ctrl0_readback: got %h expected %h", rd, ev); end
      pulse_line(9'h023);
      checks++;
      if (pending !== 4'b0000 || int_n !== 1'b1) begin errors++; $display("[TB] FAIL no_fire_high_bit: got pending %b int_n %b expected 0000 1", pending, int_n); end
      len_q.push_back(32);
      pulse_line(9'h123);
      checks++;
      if (pending !== 4'b0001) begin errors++; $display("[TB] FAIL single_pending: got %b expected 0001", pending); end
      checks++;
      if (int_n !== 1'b0) begin errors++; $display("[TB] FAIL single_int_low: got %b expected 0", int_n); end
      low = 0;
      while (int_n === 1'b0 && low < 400) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low !== len_q[0]) begin errors++; $display("[TB] FAIL single_pulse_len: got %0d expected %0d", low, len_q[0]); end
      void'(len_q.pop_front());
      exp_q.push_back(8'h01); bus_read(8'h14, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev) begin errors++; $display("[TB] FAIL single_status: got %h expected %h", rd, ev); end
   endtask

   task automatic test_ack();
      logic [7:0] rd, ev;
      logic       ro;
      int         guard;
      bus_write(8'h14, 8'h01);
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL ack_pending: got %b expected 0000", pending); end
      exp_q.push_back(8'h00); bus_read(8'h14, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev) begin errors++; $display("[TB] FAIL ack_status: got %h expected %h", rd, ev); end
      @(negedge clk);
      vcount      = 9'h123;
      line_start  = 1'b1;
      zxuno_addr  = 8'h14;
      din         = 8'h01;
      zxuno_regwr = 1'b1;
      @(negedge clk);
      line_start  = 1'b0;
      zxuno_regwr = 1'b0;
      checks++;
      if (pending[0] !== 1'b1) begin errors++; $display("[TB] FAIL set_clear_collision: got %b expected 1", pending[0]); end
      guard = 0;
      while (int_n === 1'b0 && guard < 400) begin
         guard++;
         @(negedge clk);
      end
      bus_write(8'h14, 8'h81);
      checks++;
      if (vretraceint_disable !== 1'b1 || pending !== 4'b0000) begin errors++; $display("[TB] FAIL vret_set: got vret %b pending %b expected 1 0000", vretraceint_disable, pending); end
      exp_q.push_back(8'h80); bus_read(8'h14, rd, ro); ev = exp_q.pop_front();
      checks++;
      if (rd !== ev) begin errors++; $display("[TB] FAIL vret_readback: got %h expected %h", rd, ev); end
      bus_write(8'h14, 8'h00);
   endtask

   task automatic test_enable_edge();
      bus_write(8'h0D, 8'h01);
      @(negedge clk);
      vcount      = 9'h123;
      line_start  = 1'b1;
      zxuno_addr  = 8'h0D;
      din         = 8'h81;
      zxuno_regwr = 1'b1;
      @(negedge clk);
      line_start  = 1'b0;
      zxuno_regwr = 1'b0;
      checks++;
      if (pending !== 4'b0000 || int_n !== 1'b1) begin errors++; $display("[TB] FAIL enable_same_edge: got pending %b int_n %b expected 0000 1", pending, int_n); end
      bus_write(8'h0D, 8'h01);
   endtask

   task automatic test_multi_channel();
      int low;
      bus_write(8'h0E, 8'h28); bus_write(8'h0F, 8'h80);
      bus_write(8'h10, 8'h28); bus_write(8'h11, 8'h80);
      bus_write(8'h12, 8'h29); bus_write(8'h13, 8'h80);
      len_q.push_back(32);
      pulse_line(9'd40);
      checks++;
      if (pending !== 4'b0110 || int_n !== 1'b0) begin errors++; $display("[TB] FAIL multi_first: got pending %b int_n %b expected 0110 0", pending, int_n); end
      low = 1;
      repeat (9) begin
         @(negedge clk);
         if (int_n === 1'b0) low++;
      end
      @(negedge clk);
      if (int_n === 1'b0) low++;
      vcount     = 9'd41;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      if (int_n === 1'b0) low++;
      checks++;
      if (pending !== 4'b1110) begin errors++; $display("[TB] FAIL multi_second: got %b expected 1110", pending); end
      while (int_n === 1'b0 && low < 400) begin
         @(negedge clk);
         if (int_n === 1'b0) low++;
      end
      checks++;
      if (low !== len_q[0]) begin errors++; $display("[TB] FAIL multi_pulse_len: got %0d expected %0d", low, len_q[0]); end
      void'(len_q.pop_front());
      bus_write(8'h14, 8'h0F);
   endtask

   task automatic test_async_reset();
      pulse_line(9'd40);
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL async_int_n: got %b expected 1", int_n); end
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL async_pending: got %b expected 0000", pending); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_hpos();
      logic [7:0] rd;
      logic       ro;
      bus_read(8'h0B, rd, ro);
      checks++;
      if (ro !== 1'b0 || rd !== 8'hFF) begin errors++; $display("[TB] FAIL below_base: got %h oe %b expected ff oe 0", rd, ro); end
`ifdef RASTERINT_HPOS_EN
      bus_write(8'h0C, 8'd50);
      bus_write(8'h0D, 8'hA0);
      bus_write(8'h15, 8'h00);
      @(negedge clk);
      vcount = 9'd50;
      hcount = 9'h0FF;
      @(negedge clk);
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL hpos_no_fire: got %b expected 0000", pending); end
      hcount = 9'h100;
      @(negedge clk);
      hcount = 9'h000;
      checks++;
      if (pending !== 4'b0001 || int_n !== 1'b0) begin errors++; $display("[TB] FAIL hpos_fire: got pending %b int_n %b expected 0001 0", pending, int_n); end
`else
      bus_read(8'h15, rd, ro);
      checks++;
      if (ro !== 1'b0 || rd !== 8'hFF) begin errors++; $display("[TB] FAIL hpos_unclaimed: got %h oe %b expected ff oe 0", rd, ro); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_fire();
      test_ack();
      test_enable_edge();
      test_multi_channel();
      test_async_reset();
      test_hpos();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
